silent_sched: RTL and testbench

Sequencer for the silent-mode step limiter. It generates periodic update ticks from a programmable cycle counter. On each tick it sweeps one shared step-limit datapath over all DEPTH transducer channels through a valid/ready handshake, so a single time-multiplexed LPF lane replaces DEPTH parallel lanes. It sits between the control registers (ENABLE, UPDATE_CYCLE, STEP) and the shared LPF lane.

---
 rtl/silent_sched.sv | 186 ++++++++++++++++++
 tb/tb_silent_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/silent_sched.sv
// -----------------------------------------------------------------------------
// silent_sched
//
// Sequencer for the silent-mode step limiter. A programmable cycle counter
// produces periodic update ticks; each accepted tick launches one sweep of a
// shared step-limit lane over all DEPTH transducer channels through a
// valid/ready handshake, so one time-multiplexed LPF lane serves every channel.
//
// Parameters:
//   WIDTH  - width of cycle and step quantities
//   DEPTH  - channels per sweep
//   ADDR_W - channel index width (2**ADDR_W must be >= DEPTH)
//
// Ports:
//   i_clk           system clock
//   i_rst_n         synchronous active-low reset
//   i_sync          single-cycle pulse, realigns the tick counter to 0
//   i_enable        silent-mode enable, gates tick acceptance
//   i_update_cycle  tick period in clock cycles (0 behaves as 1)
//   i_step          step limit, sampled when a sweep starts
//   o_ch_valid      channel request valid
//   i_ch_ready      LPF lane accepts the current request
//   o_ch_addr       channel index of the current request
//   o_ch_step       step value latched for the running sweep
//   o_ch_last       high with o_ch_valid on the final channel
//   o_busy          sweep in progress
//   o_overrun       sticky: a tick was dropped
//   i_clr_overrun   clears o_overrun and o_overrun_cnt
//   o_overrun_cnt   dropped-tick count
//
// Build option:
//   SILENT_SCHED_OVERRUN_CNT_EN - when defined, o_overrun_cnt is a saturating
//   16-bit dropped-tick counter; otherwise it is tied to zero and no counter
//   logic exists. The o_overrun flag is present in both builds.
// -----------------------------------------------------------------------------
module silent_sched #(
  parameter int WIDTH  = 13,
  parameter int DEPTH  = 249,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sync,
  input  logic              i_enable,
  input  logic [WIDTH-1:0]  i_update_cycle,
  input  logic [WIDTH-1:0]  i_step,
  output logic              o_ch_valid,
  input  logic              i_ch_ready,
  output logic [ADDR_W-1:0] o_ch_addr,
  output logic [WIDTH-1:0]  o_ch_step,
  output logic              o_ch_last,
  output logic              o_busy,
  output logic              o_overrun,
  input  logic              i_clr_overrun,
  output logic [15:0]       o_overrun_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_cnt;
  logic              r_tick;
  logic              r_pend;
  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_step;
  logic              r_last;
  logic              r_overrun;

  logic [WIDTH-1:0]  w_limit_m1;
  logic              w_wrap;
  logic              w_tick_acc;
  logic              w_xfer;
  logic              w_drop;
  logic [ADDR_W-1:0] w_addr_nxt;

  // ---- stage: tick generation ----
  // A period of 0 behaves as 1. The >= compare makes a shortened period take
  // effect on the next cycle instead of letting the counter run to wrap-around.
  assign w_limit_m1 = (i_update_cycle == '0) ? '0 : i_update_cycle - WIDTH'(1);
  assign w_wrap     = (r_cnt >= w_limit_m1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_sync) begin
      // realignment suppresses any tick that would have fired this cycle
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + WIDTH'(1);
      r_tick <= 1'b0;
    end
  end

  // ---- stage: sweep sequencer ----
  assign w_tick_acc = r_tick & i_enable;
  assign w_xfer     = r_valid & i_ch_ready;
  // one tick may wait in PEND; a second one arriving mid-sweep is lost
  assign w_drop     = (r_state == ST_SWEEP) & w_tick_acc & r_pend;
  assign w_addr_nxt = r_addr + ADDR_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_step  <= '0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // a pending tick is serviced even if enable has since dropped
          if (w_tick_acc || r_pend) begin
            r_state <= ST_SWEEP;
            r_valid <= 1'b1;
            r_addr  <= '0;
            r_step  <= i_step;
            r_last  <= (DEPTH == 1);
            // a fresh tick coinciding with a pending start becomes the next pend
            r_pend  <= r_pend & w_tick_acc;
          end
        end
        ST_SWEEP: begin
          if (w_tick_acc) r_pend <= 1'b1;
          if (w_xfer) begin
            if (r_last) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              r_addr <= w_addr_nxt;
              r_last <= (w_addr_nxt == LAST_ADDR);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage: overrun tracking ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)          r_overrun <= 1'b0;
    else if (w_drop)       r_overrun <= 1'b1;  // set beats a same-cycle clear
    else if (i_clr_overrun) r_overrun <= 1'b0;
  end

`ifdef SILENT_SCHED_OVERRUN_CNT_EN
  logic [15:0] r_ovr_cnt;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ovr_cnt <= '0;
    end else if (w_drop) begin
      // a clear in the same cycle still counts the tick being dropped now
      r_ovr_cnt <= i_clr_overrun ? 16'd1 : sat_inc16(r_ovr_cnt);
    end else if (i_clr_overrun) begin
      r_ovr_cnt <= '0;
    end
  end

  assign o_overrun_cnt = r_ovr_cnt;
`else
  assign o_overrun_cnt = '0;
`endif

  assign o_ch_valid = r_valid;
  assign o_ch_addr  = r_addr;
  assign o_ch_step  = r_step;
  assign o_ch_last  = r_last;
  assign o_busy     = (r_state == ST_SWEEP);
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_silent_sched.sv
// -----------------------------------------------------------------------------
// tb_silent_sched
//
// Directed bench for silent_sched (WIDTH=13, DEPTH=249, ADDR_W=8). The
// stimulus process queues the expected {addr, step, last} for every channel
// of each sweep it provokes; a negedge monitor pops one entry per handshake.
// Timing points (sweep start, length, gaps) are checked in the stimulus
// process against cycle numbers derived from the tick counter behaviour.
// -----------------------------------------------------------------------------
module tb_silent_sched;

  logic        clk = 1'b0;
  logic        rst_n, sync, en, ready, clr;
  logic [12:0] ucyc, step;
  logic        o_ch_valid, o_ch_last, o_busy, o_overrun;
  logic [7:0]  o_ch_addr;
  logic [12:0] o_ch_step;
  logic [15:0] o_overrun_cnt;

`ifdef SILENT_SCHED_OVERRUN_CNT_EN
  localparam int OVR_EN = 1;
`else
  localparam int OVR_EN = 0;
`endif

  always #5 clk = ~clk;

  silent_sched #(.WIDTH(13), .DEPTH(249), .ADDR_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sync(sync), .i_enable(en),
    .i_update_cycle(ucyc), .i_step(step),
    .o_ch_valid(o_ch_valid), .i_ch_ready(ready), .o_ch_addr(o_ch_addr),
    .o_ch_step(o_ch_step), .o_ch_last(o_ch_last), .o_busy(o_busy),
    .o_overrun(o_overrun), .i_clr_overrun(clr), .o_overrun_cnt(o_overrun_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer = 0;
  logic [21:0] sb[$];
  logic [21:0] m_exp;
  logic        prev_stall = 1'b0;
  logic [22:0] prev_out;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one scoreboard entry per handshake; outputs must hold while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall)
        check("stall_hold", int'({o_ch_valid, o_ch_addr, o_ch_step, o_ch_last}),
              int'(prev_out));
      if (o_ch_valid && ready) begin
        n_xfer++;
        if (sb.size() == 0) begin
          check("unexpected_xfer", int'(o_ch_addr), -1);
        end else begin
          m_exp = sb.pop_front();
          check("xfer", int'({o_ch_addr, o_ch_step, o_ch_last}), int'(m_exp));
        end
      end
      prev_stall = o_ch_valid && !ready;
      prev_out   = {o_ch_valid, o_ch_addr, o_ch_step, o_ch_last};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int s);
    for (int i = 0; i < 249; i++)
      sb.push_back({8'(i), 13'(s), (i == 248)});
  endtask

  // Returns the cycle at which o_ch_valid first equals lvl, or -1 on timeout.
  task automatic wait_vld(input logic lvl, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (o_ch_valid == lvl) begin
        at = cyc;
        break;
      end
      tick1();
    end
  endtask

  // Reset, then release; the tick counter reads 0 during the returned cycle.
  task automatic do_reset(output int c0);
    rst_n = 1'b0;
    sb.delete();
    repeat (2) tick1();
    rst_n = 1'b1;
    c0 = cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a, b, c, d, nv, k, s;
    rst_n = 1'b0; sync = 1'b0; en = 1'b0; ready = 1'b1; clr = 1'b0;
    ucyc = 13'd300; step = 13'd0;
    repeat (3) tick1();

    // reset values
    check("rst_valid", int'(o_ch_valid), 0);
    check("rst_addr",  int'(o_ch_addr), 0);
    check("rst_step",  int'(o_ch_step), 0);
    check("rst_last",  int'(o_ch_last), 0);
    check("rst_busy",  int'(o_busy), 0);
    check("rst_ovr",   int'(o_overrun), 0);
    check("rst_ovrcnt", int'(o_overrun_cnt), 0);

    // 1: period 300, full-rate sweeps
    ucyc = 13'd300; step = 13'd5; en = 1'b1; ready = 1'b1;
    do_reset(c0);
    push_sweep(5); push_sweep(5);
    wait_vld(1'b1, 400, a);
    check("t1_first", a, c0 + 301);
    check("t1_busy", int'(o_busy), 1);
    wait_vld(1'b0, 300, b);
    check("t1_len", b - a, 249);
    wait_vld(1'b1, 400, c);
    check("t1_period", c - a, 300);
    check("t1_ovr", int'(o_overrun), 0);
    wait_vld(1'b0, 300, b);
    check("t1_drain", sb.size(), 0);

    // 2: period 100 -> pend, then overrun; STEP changes mid-sweep
    ucyc = 13'd100; step = 13'd7; en = 1'b1;
    do_reset(c0);
    push_sweep(7); push_sweep(9);
    wait_vld(1'b1, 200, a);
    check("t2_first", a, c0 + 101);
    while (cyc < c0 + 150) tick1();
    step = 13'd9;
    wait_vld(1'b0, 300, b);
    check("t2_lenA", b - a, 249);
    check("t2_ovr", int'(o_overrun), 1);
    check("t2_ovrcnt", int'(o_overrun_cnt), OVR_EN);
    wait_vld(1'b1, 10, c);
    check("t2_gap", c - b, 1);
    tick1();
    en = 1'b0; step = 13'd11;
    wait_vld(1'b0, 300, d);
    check("t2_lenB", d - c, 249);
    check("t2_drain", sb.size(), 0);
    check("t2_ovr_sticky", int'(o_overrun), 1);
    check("t2_ovrcnt2", int'(o_overrun_cnt), OVR_EN);
    clr = 1'b1;
    tick1();
    clr = 1'b0;
    check("t2_clr_ovr", int'(o_overrun), 0);
    check("t2_clr_cnt", int'(o_overrun_cnt), 0);

    // 3: ready pattern 1,0,0,1
    ucyc = 13'd1000; step = 13'd3; en = 1'b1; ready = 1'b1;
    do_reset(c0);
    push_sweep(3);
    n_xfer = 0;
    s = 0; d = 0;
    for (k = 0; k < 1800 && d == 0; k++) begin
      ready = ((k % 4) == 0) || ((k % 4) == 3);
      tick1();
      if (o_ch_valid) s = 1;
      else if (s != 0) d = 1;
    end
    ready = 1'b1;
    check("t3_done", d, 1);
    check("t3_count", n_xfer, 249);
    check("t3_drain", sb.size(), 0);

    // 4: ENABLE low for 3 periods, then enable drops mid-sweep
    ucyc = 13'd120; step = 13'd4; en = 1'b0;
    do_reset(c0);
    nv = 0;
    while (cyc < c0 + 370) begin
      if (o_ch_valid) nv++;
      tick1();
    end
    check("t4_nosweep", nv, 0);
    check("t4_ovr", int'(o_overrun), 0);
    en = 1'b1;
    push_sweep(4);
    wait_vld(1'b1, 200, a);
    check("t4_first", a, c0 + 481);
    for (k = 0; k < 300; k++) begin
      if (o_ch_addr == 8'd100) break;
      tick1();
    end
    en = 1'b0;
    wait_vld(1'b0, 300, b);
    check("t4_len", b - a, 249);
    check("t4_drain", sb.size(), 0);
    wait_vld(1'b1, 300, c);
    check("t4_no_more", c, -1);

    // 5: reset in the middle of a sweep
    ucyc = 13'd100; step = 13'd6; en = 1'b1;
    do_reset(c0);
    push_sweep(6);
    wait_vld(1'b1, 200, a);
    for (k = 0; k < 100; k++) begin
      if (o_ch_addr == 8'd50) break;
      tick1();
    end
    check("t5_at50", int'(o_ch_addr), 50);
    rst_n = 1'b0;
    tick1();
    check("t5_rst_valid", int'(o_ch_valid), 0);
    check("t5_rst_addr", int'(o_ch_addr), 0);
    check("t5_rst_step", int'(o_ch_step), 0);
    check("t5_rst_busy", int'(o_busy), 0);
    sb.delete();
    tick1();
    rst_n = 1'b1;
    c0 = cyc;
    push_sweep(6);
    wait_vld(1'b1, 200, a);
    check("t5_restart", a, c0 + 101);
    check("t5_addr0", int'(o_ch_addr), 0);
    tick1();
    en = 1'b0;
    wait_vld(1'b0, 300, b);
    check("t5_drain", sb.size(), 0);

    // 6: SYNC at CNT=150 with period 300
    ucyc = 13'd300; step = 13'd2; en = 1'b1;
    do_reset(c0);
    push_sweep(2);
    while (cyc < c0 + 150) tick1();
    s = cyc;
    sync = 1'b1;
    tick1();
    sync = 1'b0;
    wait_vld(1'b1, 400, a);
    check("t6_sync", a, s + 302);
    tick1();
    en = 1'b0;
    wait_vld(1'b0, 300, b);
    check("t6_drain", sb.size(), 0);

    // 7: period shrinks below the current count -> wrap next cycle
    ucyc = 13'd300; step = 13'd8; en = 1'b1;
    do_reset(c0);
    push_sweep(8);
    while (cyc < c0 + 200) tick1();
    ucyc = 13'd100;
    wait_vld(1'b1, 50, a);
    check("t7_shrink", a, c0 + 202);
    tick1();
    en = 1'b0;
    wait_vld(1'b0, 300, b);
    check("t7_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
